uart_echo_ctrl: RTL and testbench

- Parametrised successor to the board-level UART echo path.
- Sits between the existing uart_rx and uart_tx instances.
- Buffers received bytes in a DEPTH-entry FIFO and forwards them in one of four modes: echo, upper-case, line-buffered, mute.
- Keeps wrapping rx/tx byte counters, a FIFO level and a sticky overflow flag for the digital-tube and LED displays.

---
 rtl/uart_echo_pkg.sv | 25 ++
 rtl/uart_echo_ctrl_if.sv | 31 +++
 rtl/uart_echo_ctrl_byte_fifo.sv | 66 ++++++
 rtl/uart_echo_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_echo_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_echo_pkg.sv
// Shared constants and helpers for the UART echo controller.
package uart_echo_pkg;

    // Forwarding modes as driven on the mode input.
    typedef enum logic [1:0] {
        MODE_ECHO  = 2'b00,
        MODE_UPPER = 2'b01,
        MODE_LINE  = 2'b10,
        MODE_MUTE  = 2'b11
    } mode_e;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LA  = 8'h61;
    localparam logic [7:0] CHAR_LZ  = 8'h7A;
    localparam logic [7:0] CASE_OFS = 8'h20;

    // Lower-case ASCII letters map to upper case; every other byte passes through.
    function automatic logic [7:0] to_upper(logic [7:0] b);
        if (b >= CHAR_LA && b <= CHAR_LZ) begin
            return b - CASE_OFS;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_echo_ctrl_if.sv
// Byte handshake between uart_rx / uart_tx and the echo controller.
interface uart_echo_ctrl_if;

    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_clear;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_avai;

    // Controller side.
    modport master (
        input  rx_data,
        input  rx_ready,
        input  tx_avai,
        output rx_clear,
        output tx_data,
        output tx_start
    );

    // UART side.
    modport slave (
        output rx_data,
        output rx_ready,
        output tx_avai,
        input  rx_clear,
        input  tx_data,
        input  tx_start
    );

endinterface

// File: rtl/uart_echo_ctrl_byte_fifo.sv
// First-word fall-through byte FIFO; DEPTH must be a power of two.
// A push while full is accepted when a pop happens in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    // Qualify requests so the FIFO can never underflow or overwrite a live entry.
    always_comb begin
        do_pop  = pop & (level_q != '0);
        do_push = push & ((level_q != LVL_FULL) | do_pop);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array, written without reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/uart_echo_ctrl.sv
// UART echo controller: buffers bytes from uart_rx and forwards them to
// uart_tx in echo, upper-case, line-buffered or mute mode, with status for
// the board displays.
module uart_echo_ctrl
    import uart_echo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    uart_echo_ctrl_if.master       uart,
    output logic [CNT_W-1:0]       rx_count,
    output logic [CNT_W-1:0]       tx_count,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]    LVL_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    mode_e           mode_s;
    logic            ingest;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            drop;
    logic            tx_go;
    logic            fifo_clr;
    logic [7:0]      store_byte;
    logic [7:0]      fifo_dout;
    logic [LW-1:0]   fifo_level;
    logic [LW-1:0]   level_nxt;
    logic            flush_q;
    logic            overflow_q;
    logic [CNT_W-1:0] rx_count_q;
    logic [CNT_W-1:0] tx_count_q;

    assign mode_s   = mode_e'(mode);
    assign fifo_clr = ~en;

    // Handshake decode: what is consumed, stored, dropped and sent this cycle.
    always_comb begin
        ingest     = ~rst & en & uart.rx_ready;
        push_req   = ingest & (mode_s != MODE_MUTE);
        tx_go      = ~rst & en & (fifo_level != '0) & ((mode_s != MODE_LINE) | flush_q);
        pop        = tx_go & uart.tx_avai;
        push       = push_req & ((fifo_level != LVL_FULL) | pop);
        drop       = push_req & ~push;
        store_byte = (mode_s == MODE_UPPER) ? to_upper(uart.rx_data) : uart.rx_data;
    end

    // Occupancy after this edge, used to steer the line flush flag.
    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + LVL_ONE;
        end else if (!push && pop) begin
            level_nxt = fifo_level - LVL_ONE;
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (fifo_clr),
        .din   (store_byte),
        .dout  (fifo_dout),
        .level (fifo_level)
    );

    // Line flush: opens on CR or a full FIFO, closes once drained; set wins.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            flush_q <= 1'b0;
        end else if ((push && store_byte == CHAR_CR) || level_nxt == LVL_FULL) begin
            flush_q <= 1'b1;
        end else if (level_nxt == '0) begin
            flush_q <= 1'b0;
        end
    end

    // Sticky overflow, cleared only by reset or disable.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // Wrapping byte counters; they hold while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count_q <= '0;
            tx_count_q <= '0;
        end else begin
            if (ingest) begin
                rx_count_q <= rx_count_q + CNT_ONE;
            end
            if (pop) begin
                tx_count_q <= tx_count_q + CNT_ONE;
            end
        end
    end

    // A stale uart_rx byte is discarded during reset and while disabled.
    assign uart.rx_clear = rst | ~en | uart.rx_ready;
    assign uart.tx_start = tx_go;
    assign uart.tx_data  = fifo_dout;

    assign rx_count = rx_count_q;
    assign tx_count = tx_count_q;
    assign level    = fifo_level;
    assign overflow = overflow_q;
    assign busy     = (fifo_level != '0);

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl: directed test-plan steps followed
// by a randomized phase, all checked against a queue-based reference model.
module tb_uart_echo_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             busy;

    uart_echo_ctrl_if bus ();

    uart_echo_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .uart     (bus),
        .rx_count (rx_count),
        .tx_count (tx_count),
        .level    (level),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] q_m[$];
    bit         ovf_m;
    bit         flush_m;
    int         rxc_m;
    int         txc_m;
    logic [7:0] dut_sent[$];
    logic [1:0] cur_mode;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic step(input bit r_rst, input bit r_en, input logic [1:0] r_mode,
                        input bit r_rdy, input logic [7:0] r_data, input bit r_avai);
        bit exp_clear;
        bit exp_start;
        bit popd;
        bit pushd;
        logic [7:0] b;
        @(negedge clk);
        rst          = r_rst;
        en           = r_en;
        mode         = r_mode;
        bus.rx_ready = r_rdy;
        bus.rx_data  = r_data;
        bus.tx_avai  = r_avai;
        #1;
        exp_clear = r_rst || !r_en || r_rdy;
        exp_start = !r_rst && r_en && (q_m.size() != 0) && (r_mode != 2'd2 || flush_m);
        check("rx_clear", 32'(bus.rx_clear), 32'(exp_clear));
        check("tx_start", 32'(bus.tx_start), 32'(exp_start));
        check("level", 32'(level), q_m.size());
        check("busy", 32'(busy), 32'(q_m.size() != 0));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("rx_count", 32'(rx_count), rxc_m);
        check("tx_count", 32'(tx_count), txc_m);
        if (q_m.size() != 0) begin
            check("tx_data", 32'(bus.tx_data), 32'(q_m[0]));
        end
        if (bus.tx_start && r_avai) begin
            dut_sent.push_back(bus.tx_data);
        end
        if (r_rst) begin
            q_m.delete();
            ovf_m   = 1'b0;
            flush_m = 1'b0;
            rxc_m   = 0;
            txc_m   = 0;
        end else if (!r_en) begin
            q_m.delete();
            ovf_m   = 1'b0;
            flush_m = 1'b0;
        end else begin
            popd  = exp_start && r_avai;
            pushd = 1'b0;
            b     = r_data;
            if (r_rdy) begin
                rxc_m = (rxc_m + 1) % (1 << CNT_W);
                if (r_mode != 2'd3) begin
                    if (r_mode == 2'd1 && r_data >= "a" && r_data <= "z") begin
                        b = r_data - 8'd32;
                    end
                    if (q_m.size() < DEPTH || popd) begin
                        pushd = 1'b1;
                    end else begin
                        ovf_m = 1'b1;
                    end
                end
            end
            if (popd) begin
                void'(q_m.pop_front());
                txc_m = (txc_m + 1) % (1 << CNT_W);
            end
            if (pushd) begin
                q_m.push_back(b);
            end
            if ((pushd && b == 8'h0D) || q_m.size() == DEPTH) begin
                flush_m = 1'b1;
            end else if (q_m.size() == 0) begin
                flush_m = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input bit avai);
        step(1'b0, 1'b1, cur_mode, 1'b1, d, avai);
    endtask

    task automatic idle(input int n, input bit avai);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, cur_mode, 1'b0, 8'h00, avai);
        end
    endtask

    initial begin
        logic [7:0] exp_bytes[$];
        int         saved_rx;

        // Settle the DUT out of X before any comparison.
        rst          = 1'b1;
        en           = 1'b0;
        mode         = 2'd0;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_avai  = 1'b0;
        cur_mode     = 2'd0;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b1, 2'd0, 1'b1, 8'hAA, 1'b1);

        // ECHO: two bytes, one-cycle latency, counters and level.
        dut_sent.delete();
        send(8'h41, 1'b1);
        send(8'h62, 1'b1);
        idle(3, 1'b1);
        check("echo_cnt", dut_sent.size(), 2);
        if (dut_sent.size() == 2) begin
            check("echo_b0", 32'(dut_sent[0]), 32'h41);
            check("echo_b1", 32'(dut_sent[1]), 32'h62);
        end
        check("echo_rxc", 32'(rx_count), 2);
        check("echo_txc", 32'(tx_count), 2);
        check("echo_lvl", 32'(level), 0);

        // UPPER
        cur_mode = 2'd1;
        dut_sent.delete();
        send(8'h61, 1'b1);
        send(8'h5A, 1'b1);
        send(8'h7B, 1'b1);
        idle(4, 1'b1);
        exp_bytes = '{8'h41, 8'h5A, 8'h7B};
        check("upper_cnt", dut_sent.size(), 3);
        foreach (exp_bytes[i]) begin
            if (i < dut_sent.size()) check("upper_byte", 32'(dut_sent[i]), 32'(exp_bytes[i]));
        end

        // LINE: hold until CR, then release, then hold again.
        cur_mode = 2'd2;
        dut_sent.delete();
        send(8'h68, 1'b1);
        send(8'h69, 1'b1);
        idle(3, 1'b1);
        check("line_hold_start", 32'(bus.tx_start), 0);
        check("line_hold_lvl", 32'(level), 2);
        send(8'h0D, 1'b1);
        idle(5, 1'b1);
        exp_bytes = '{8'h68, 8'h69, 8'h0D};
        check("line_cnt", dut_sent.size(), 3);
        foreach (exp_bytes[i]) begin
            if (i < dut_sent.size()) check("line_byte", 32'(dut_sent[i]), 32'(exp_bytes[i]));
        end
        send(8'h78, 1'b1);
        idle(2, 1'b1);
        check("line_reheld_lvl", 32'(level), 1);
        check("line_reheld_start", 32'(bus.tx_start), 0);
        cur_mode = 2'd0;
        idle(2, 1'b1);
        check("line_release_lvl", 32'(level), 0);

        // Overflow: 18 bytes into a stalled FIFO, then drain the first 16.
        step(1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0);
        dut_sent.delete();
        for (int i = 0; i < 18; i++) send(8'(8'h30 + i), 1'b0);
        idle(1, 1'b0);
        check("ovf_lvl", 32'(level), 16);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_rxc", 32'(rx_count), 18 % 16);
        idle(20, 1'b1);
        check("ovf_sent", dut_sent.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < dut_sent.size()) check("ovf_order", 32'(dut_sent[i]), 32'(8'h30 + i));
        end
        check("ovf_sticky", 32'(overflow), 1);

        // Simultaneous push and pop while full.
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
        send(8'h55, 1'b1);
        idle(1, 1'b0);
        check("simul_lvl", 32'(level), 16);
        check("simul_ovf", 32'(overflow), 0);

        // Disable for one cycle with five bytes stored.
        idle(20, 1'b1);
        for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b0);
        saved_rx = rxc_m;
        step(1'b0, 1'b0, 2'd0, 1'b1, 8'h11, 1'b1);
        idle(1, 1'b0);
        check("dis_lvl", 32'(level), 0);
        check("dis_ovf", 32'(overflow), 0);
        check("dis_rxc_held", 32'(rx_count), saved_rx);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) send(8'(8'h70 + i), 1'b0);
        step(1'b1, 1'b1, 2'd0, 1'b1, 8'h22, 1'b1);
        idle(1, 1'b0);
        check("rst_lvl", 32'(level), 0);
        check("rst_rxc", 32'(rx_count), 0);
        check("rst_txc", 32'(tx_count), 0);
        check("rst_start", 32'(bus.tx_start), 0);

        // Counter wrap at CNT_W = 4.
        for (int i = 0; i < 17; i++) send(8'(i), 1'b1);
        idle(2, 1'b1);
        check("wrap_rxc", 32'(rx_count), 1);
        check("wrap_txc", 32'(tx_count), 1);

        // Randomized phase against the model.
        for (int i = 0; i < 800; i++) begin
            int         r;
            logic [7:0] d;
            if ($urandom_range(0, 19) == 0) cur_mode = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       d = 8'($urandom_range(8'h61, 8'h7A));
                1:       d = 8'h0D;
                default: d = 8'($urandom);
            endcase
            step(r == 0, r != 1, cur_mode, $urandom_range(0, 2) != 0, d,
                 $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
